// File: rtl/cp0_exc_ctrl_pkg.sv
// CP0 register addresses, exception codes and the exception priority encoder
// shared by the exception controller and its timer.
package cp0_exc_ctrl_pkg;

  localparam logic [5:0] CP0ADDR_BADVADDR = 6'd8;
  localparam logic [5:0] CP0ADDR_COUNT    = 6'd9;
  localparam logic [5:0] CP0ADDR_COMPARE  = 6'd11;
  localparam logic [5:0] CP0ADDR_STATUS   = 6'd12;
  localparam logic [5:0] CP0ADDR_CAUSE    = 6'd13;
  localparam logic [5:0] CP0ADDR_EPC      = 6'd14;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
  // Only BEV is set at reset, and BEV is hardwired, so this doubles as the read mask.
  localparam logic [31:0] STATUS_RST = 32'h0040_0000;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c
  } exc_code_e;

  typedef enum logic [1:0] {
    BADV_NONE,
    BADV_PC,
    BADV_DATA
  } badv_src_e;

  typedef struct packed {
    exc_code_e code;
    badv_src_e badv;
  } exc_sel_t;

  // flags = {AdEL_fetch, RI, Ov, Sys, Bp, AdEL_data, AdES}
  function automatic exc_sel_t exc_prioritise(input logic int_pend, input logic [6:0] flags);
    exc_sel_t s;
    s.code = EXC_INT;
    s.badv = BADV_NONE;
    if (int_pend)      s.code = EXC_INT;
    else if (flags[6]) begin s.code = EXC_ADEL; s.badv = BADV_PC;   end
    else if (flags[5]) s.code = EXC_RI;
    else if (flags[4]) s.code = EXC_OV;
    else if (flags[3]) s.code = EXC_SYS;
    else if (flags[2]) s.code = EXC_BP;
    else if (flags[1]) begin s.code = EXC_ADEL; s.badv = BADV_DATA; end
    else if (flags[0]) begin s.code = EXC_ADES; s.badv = BADV_DATA; end
    return s;
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_timer.sv
// Count/Compare timer: Count advances every second clock, TI latches on a
// Count==Compare match and is cleared only by a Compare write.
module cp0_timer
  import cp0_exc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;
  logic        ti_q, ti_d;

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    tick_d    = ~tick_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      count_d = wdata_i;
      tick_d  = 1'b0;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end
    if (compare_we_i) compare_d = wdata_i;
    // A Compare write beats a match on the same edge.
    if (compare_we_i)
      ti_d = 1'b0;
    else if (tick_q && (count_q == compare_q) && (compare_q != 32'd0))
      ti_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      tick_q    <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= tick_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// WB-stage exception controller and Status/Cause/BadVAddr (+Count/Compare) CP0 file.
// Count/Compare and the timer interrupt exist only when CP0_TIMER_INT_EN is defined.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [31:0] mem_to_wb_PC_r,
  input  logic        wb_in_delay_slot,
  input  logic [6:0]  wb_exc_flags,
  input  logic [31:0] wb_badvaddr,
  input  logic        wb_eret,
  input  logic [5:0]  hw_int,
  input  logic        mtc0_we,
  input  logic [5:0]  cp0_addr,
  input  logic [31:0] mct0_data,
  input  logic [5:0]  cp0_raddr,
  input  logic [31:0] cp0_EPC_data,
  output logic [31:0] cp0_rdata,
  output logic        exception,
  output logic        EXL,
  output logic        BD,
  output logic        flush,
  output logic [31:0] redirect_pc
);

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [5:0]  ip_hw_q;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        ti;
  logic [31:0] count_val, compare_val;
  logic [7:0]  ip_eff;
  logic        int_pend, eret_taken, status_we, cause_we;
  exc_sel_t    exc_sel;

  wire unused_ok = ^{mct0_data[31:16], mct0_data[7:2]};

`ifdef CP0_TIMER_INT_EN
  cp0_timer u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .count_we_i   (mtc0_we && (cp0_addr == CP0ADDR_COUNT)),
    .compare_we_i (mtc0_we && (cp0_addr == CP0ADDR_COMPARE)),
    .wdata_i      (mct0_data),
    .count_o      (count_val),
    .compare_o    (compare_val),
    .ti_o         (ti)
  );
`else
  assign count_val   = 32'd0;
  assign compare_val = 32'd0;
  assign ti          = 1'b0;
`endif

  assign ip_eff     = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};
  assign int_pend   = wb_valid & ie_q & ~exl_q & (|(ip_eff & im_q));
  assign exc_sel    = exc_prioritise(int_pend, wb_exc_flags);
  assign exception  = wb_valid & (int_pend | (|wb_exc_flags));
  assign eret_taken = wb_valid & wb_eret & ~exception;
  assign flush      = exception | eret_taken;
  assign BD         = wb_in_delay_slot;
  assign EXL        = exl_q;
  assign redirect_pc = exception  ? EXC_VECTOR :
                       eret_taken ? cp0_EPC_data : 32'd0;

  // Exception entry owns Status/Cause on its edge; other CP0 writes still land.
  assign status_we = mtc0_we & (cp0_addr == CP0ADDR_STATUS) & ~exception;
  assign cause_we  = mtc0_we & (cp0_addr == CP0ADDR_CAUSE) & ~exception;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    ip_sw_d    = ip_sw_q;
    badvaddr_d = badvaddr_q;
    if (status_we) begin
      im_d  = mct0_data[15:8];
      exl_d = mct0_data[1];
      ie_d  = mct0_data[0];
    end
    if (cause_we) ip_sw_d = mct0_data[9:8];
    if (eret_taken) exl_d = 1'b0;
    if (exception) begin
      exl_d      = 1'b1;
      exc_code_d = exc_sel.code;
      if (!exl_q) bd_d = wb_in_delay_slot;
      case (exc_sel.badv)
        BADV_PC:   badvaddr_d = mem_to_wb_PC_r;
        BADV_DATA: badvaddr_d = wb_badvaddr;
        default:   badvaddr_d = badvaddr_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= 5'd0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      badvaddr_q <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      ip_hw_q    <= hw_int;
      ip_sw_q    <= ip_sw_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // EPC is read outside this block, so it falls through to zero here.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_raddr)
      CP0ADDR_BADVADDR: cp0_rdata = badvaddr_q;
      CP0ADDR_COUNT:    cp0_rdata = count_val;
      CP0ADDR_COMPARE:  cp0_rdata = compare_val;
      CP0ADDR_STATUS:   cp0_rdata = STATUS_RST | {16'd0, im_q, 6'd0, exl_q, ie_q};
      CP0ADDR_CAUSE:    cp0_rdata = {bd_q, ti, 14'd0, ip_eff, 1'b0, exc_code_q, 2'b00};
      default:          cp0_rdata = 32'd0;
    endcase
  end

endmodule
